// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the instruction queue: entry width, field slices, default depth.
package inst_fifo_pkg;
  localparam int ENTRY_W       = 64;
  localparam int DEFAULT_DEPTH = 16;

  function automatic logic [31:0] entry_pc(input logic [ENTRY_W-1:0] e);
    return e[63:32];
  endfunction

  function automatic logic [31:0] entry_inst(input logic [ENTRY_W-1:0] e);
    return e[31:0];
  endfunction
endpackage

// File: rtl/inst_fifo.sv
// Dual-push/dual-pop show-ahead instruction queue between fetch and dual issue.
// Latency: a push is visible on the read side the cycle after it is written; reads are combinational.
// Backpressure: w_full when fewer than 2 slots are free; over-subscribed pushes are dropped whole.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] w_data_1,
  input  logic               w_data_1_ena,
  input  logic [ENTRY_W-1:0] w_data_2,
  input  logic               w_data_2_ena,
  output logic               w_full,
  output logic [ENTRY_W-1:0] fifo_r_data_1,
  output logic               fifo_r_data_1_ok,
  output logic [ENTRY_W-1:0] fifo_r_data_2,
  output logic               fifo_r_data_2_ok,
  input  logic               p_data_1,
  input  logic               p_data_2,
  output logic [AW:0]        count
);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - 2);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_p1, wr_ptr_p1;
  logic [AW:0]        count_q, count_d, free_slots;
  logic [1:0]         npush_req, npush, npop;
  logic               push_ok, we_1, we_2;

  always_comb begin
    rd_ptr_p1  = rd_ptr_q + AW'(1);
    wr_ptr_p1  = wr_ptr_q + AW'(1);
    free_slots = DEPTH_C - count_q;

    npush_req = 2'd0;
    if (w_data_1_ena) npush_req = w_data_2_ena ? 2'd2 : 2'd1;
    // Room is judged on start-of-cycle occupancy only, so pops never gate fetch combinationally.
    push_ok = ((AW+1)'(npush_req) <= free_slots);
    npush   = push_ok ? npush_req : 2'd0;

    npop = 2'd0;
    if (p_data_1 && (count_q >= (AW+1)'(1)))
      npop = (p_data_2 && (count_q >= (AW+1)'(2))) ? 2'd2 : 2'd1;

    we_1 = !flush && (npush != 2'd0);
    we_2 = !flush && (npush == 2'd2);

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(npop);
      wr_ptr_d = wr_ptr_q + AW'(npush);
      count_d  = count_q + (AW+1)'(npush) - (AW+1)'(npop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_1) mem_q[wr_ptr_q]  <= w_data_1;
    if (we_2) mem_q[wr_ptr_p1] <= w_data_2;
  end

  assign fifo_r_data_1    = mem_q[rd_ptr_q];
  assign fifo_r_data_2    = mem_q[rd_ptr_p1];
  assign fifo_r_data_1_ok = (count_q >= (AW+1)'(1));
  assign fifo_r_data_2_ok = (count_q >= (AW+1)'(2));
  assign w_full           = (count_q > FULL_TH);
  assign count            = count_q;
endmodule

// File: tb/tb_inst_fifo.sv
// Directed and randomized bench for inst_fifo against a queue-based reference model.
module tb_inst_fifo;
  import inst_fifo_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, flush, w1e, w2e, p1, p2;
  logic [63:0]   w1, w2;
  logic          w_full, ok1, ok2;
  logic [63:0]   rd1, rd2;
  logic [AW:0]   count;

  logic [63:0]   mq[$];
  int            n_cmp = 0;
  int            n_err = 0;

  inst_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .w_data_1(w1), .w_data_1_ena(w1e), .w_data_2(w2), .w_data_2_ena(w2e),
    .w_full(w_full),
    .fifo_r_data_1(rd1), .fifo_r_data_1_ok(ok1),
    .fifo_r_data_2(rd2), .fifo_r_data_2_ok(ok2),
    .p_data_1(p1), .p_data_2(p2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 64'(count), 64'(sz));
    chk({tag, ".ok1"}, 64'(ok1), 64'(sz >= 1));
    chk({tag, ".ok2"}, 64'(ok2), 64'(sz >= 2));
    chk({tag, ".w_full"}, 64'(w_full), 64'(sz > DEPTH - 2));
    if (sz >= 1) chk({tag, ".rd1"}, rd1, mq[0]);
    if (sz >= 2) chk({tag, ".rd2"}, rd2, mq[1]);
  endtask

  // One clock with the given inputs; the model applies the queue rules to start-of-cycle occupancy.
  task automatic step(input string tag, input bit f, input bit a1, input logic [63:0] d1,
                      input bit a2, input logic [63:0] d2, input bit q1, input bit q2);
    int sz, np, nu;
    flush = f; w1e = a1; w1 = d1; w2e = a2; w2 = d2; p1 = q1; p2 = q2;
    @(posedge clk);
    #1;
    sz = mq.size();
    if (f) begin
      mq.delete();
    end else begin
      np = 0;
      if (q1 && sz >= 1) np = (q2 && sz >= 2) ? 2 : 1;
      nu = a1 ? (a2 ? 2 : 1) : 0;
      if (DEPTH - sz < nu) nu = 0;
      repeat (np) void'(mq.pop_front());
      if (nu >= 1) mq.push_back(d1);
      if (nu == 2) mq.push_back(d2);
    end
    flush = 0; w1e = 0; w2e = 0; p1 = 0; p2 = 0;
    check_state(tag);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] ea, eb;
    rst = 1'b0; flush = 0; w1e = 0; w2e = 0; p1 = 0; p2 = 0; w1 = '0; w2 = '0;
    #2;
    check_state("in_reset");
    #10;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_reset");

    // First dual push becomes visible the next cycle.
    step("dual_push", 0, 1, 64'hBFC00000_24020001, 1, 64'hBFC00004_24030002, 0, 0);
    chk("dual_push.pc1", 64'(entry_pc(rd1)), 64'h0000_0000_BFC0_0000);
    chk("dual_push.pc2", 64'(entry_pc(rd2)), 64'h0000_0000_BFC0_0004);
    chk("dual_push.inst1", 64'(entry_inst(rd1)), 64'h0000_0000_2402_0001);

    step("push3", 0, 1, 64'hBFC00008_24040003, 0, 64'h0, 0, 0);
    step("pop1", 0, 0, 64'h0, 0, 64'h0, 1, 0);
    chk("pop1.head_pc", 64'(entry_pc(rd1)), 64'h0000_0000_BFC0_0004);
    step("pop2_alone", 0, 0, 64'h0, 0, 64'h0, 0, 1);
    chk("pop2_alone.count", 64'(count), 64'd2);

    // Fill to 15 and probe the full boundary.
    for (int i = 0; i < 6; i++) step("fill", 0, 1, rnd64(), 1, rnd64(), 0, 0);
    step("fill15", 0, 1, rnd64(), 0, 64'h0, 0, 0);
    chk("fill15.w_full", 64'(w_full), 64'd1);
    step("rej_dual", 0, 1, rnd64(), 1, rnd64(), 0, 0);
    chk("rej_dual.count", 64'(count), 64'd15);
    step("rej_dual_pop", 0, 1, rnd64(), 1, rnd64(), 1, 0);
    chk("rej_dual_pop.count", 64'(count), 64'd14);
    step("single_to15", 0, 1, rnd64(), 0, 64'h0, 0, 0);
    step("single_to16", 0, 1, rnd64(), 0, 64'h0, 0, 0);
    chk("full16.count", 64'(count), 64'd16);
    step("full16_push", 0, 1, rnd64(), 0, 64'h0, 1, 1);
    chk("full16_push.count", 64'(count), 64'd14);

    // Walk both pointers to DEPTH-1, then dual push/pop across the wrap.
    step("wrap_flush", 1, 0, 64'h0, 0, 64'h0, 0, 0);
    step("wrap_seed", 0, 1, rnd64(), 0, 64'h0, 0, 0);
    for (int i = 0; i < 14; i++) step("wrap_walk", 0, 1, rnd64(), 0, 64'h0, 1, 0);
    step("wrap_drain", 0, 0, 64'h0, 0, 64'h0, 1, 0);
    chk("wrap.rd_ptr15", 64'(dut.rd_ptr_q), 64'd15);
    ea = 64'hAAAA_0001_1111_0001;
    eb = 64'hBBBB_0002_2222_0002;
    step("wrap_push", 0, 1, ea, 1, eb, 0, 0);
    chk("wrap.rd1", rd1, ea);
    chk("wrap.rd2", rd2, eb);
    step("wrap_pop", 0, 0, 64'h0, 0, 64'h0, 1, 1);
    chk("wrap_pop.count", 64'(count), 64'd0);
    chk("wrap_pop.rd_ptr", 64'(dut.rd_ptr_q), 64'd1);

    // Dual pop with a single entry pops exactly one.
    step("one_push", 0, 1, rnd64(), 0, 64'h0, 0, 0);
    step("clip_pop", 0, 0, 64'h0, 0, 64'h0, 1, 1);
    chk("clip_pop.ok1", 64'(ok1), 64'd0);

    // Flush wins over simultaneous push and pop.
    for (int i = 0; i < 3; i++) step("to6", 0, 1, rnd64(), 1, rnd64(), 0, 0);
    step("flush_all", 1, 1, rnd64(), 1, rnd64(), 1, 1);
    chk("flush_all.count", 64'(count), 64'd0);

    // Asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) step("pre_arst", 0, 1, rnd64(), 1, rnd64(), 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.ok1", 64'(ok1), 64'd0);
    mq.delete();
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_arst");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rnd64(),
           ($urandom_range(0, 1) == 1), rnd64(), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
